// File: rtl/dice_roller_if.sv
// Signal bundle between a roll push-button source and the dice_roller core.
// The master drives the raw button; the slave (dice_roller) returns state and results.
interface dice_roller_if;
   logic       roll_in;
   logic       rolling;
   logic       roll_valid;
   logic [2:0] die1;
   logic [2:0] die2;
   logic [3:0] sum;

   modport master (
      output roll_in,
      input  rolling,
      input  roll_valid,
      input  die1,
      input  die2,
      input  sum
   );

   modport slave (
      input  roll_in,
      output rolling,
      output roll_valid,
      output die1,
      output die2,
      output sum
   );
endinterface

// File: rtl/dice_roller.sv
// Two-dice roller: synchronized and debounced push-button, free-running die counters
// sampled when the button is released, result held until the next roll.
module dice_roller #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input logic          clock,
   input logic          reset,
   dice_roller_if.slave bus
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRolling,
      StReport
   } state_e;

   state_e          state_q, state_d;
   logic            sync1_q;
   logic            roll_s_q;
   logic            roll_db_q, roll_db_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      die1c_q, die1c_d;
   logic [2:0]      die2c_q, die2c_d;
   logic [2:0]      die1_q, die2_q;
   logic [3:0]      sum_q;
   logic            latch;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q  <= 1'b0;
         roll_s_q <= 1'b0;
      end else begin
         sync1_q  <= bus.roll_in;
         roll_s_q <= sync1_q;
      end
   end

   // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      roll_db_d = roll_db_q;
      cnt_d     = '0;
      if (roll_s_q != roll_db_q) begin
         if (cnt_q == CntMax) begin
            roll_db_d = roll_s_q;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         roll_db_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         roll_db_q <= roll_db_d;
         cnt_q     <= cnt_d;
      end
   end

   // die2c ticks once per full die1c revolution, giving 36 distinct pairs.
   always_comb begin
      die1c_d = (die1c_q == 3'd6) ? 3'd1 : die1c_q + 3'd1;
      die2c_d = die2c_q;
      if (die1c_q == 3'd6) begin
         die2c_d = (die2c_q == 3'd6) ? 3'd1 : die2c_q + 3'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         die1c_q <= 3'd1;
         die2c_q <= 3'd1;
      end else begin
         die1c_q <= die1c_d;
         die2c_q <= die2c_d;
      end
   end

   always_comb begin
      state_d = state_q;
      latch   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (roll_db_q) state_d = StRolling;
         end
         StRolling: begin
            if (!roll_db_q) begin
               state_d = StReport;
               latch   = 1'b1;
            end
         end
         StReport: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         die1_q <= 3'd0;
         die2_q <= 3'd0;
         sum_q  <= 4'd0;
      end else if (latch) begin
         die1_q <= die1c_q;
         die2_q <= die2c_q;
         sum_q  <= {1'b0, die1c_q} + {1'b0, die2c_q};
      end
   end

   assign bus.rolling    = (state_q == StRolling);
   assign bus.roll_valid = (state_q == StReport);
   assign bus.die1       = die1_q;
   assign bus.die2       = die2_q;
   assign bus.sum        = sum_q;

   a_die_range: assert property (@(posedge clock) disable iff (!reset)
      (die1c_q inside {[3'd1:3'd6]}) && (die2c_q inside {[3'd1:3'd6]}));

   a_valid_pulse: assert property (@(posedge clock) disable iff (!reset)
      bus.roll_valid |=> !bus.roll_valid);

endmodule

// File: doc/dice_roller.md
DICE_ROLLER -- requirements
Module: dice_roller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive sampled cycles a synchronized input change must persist before it is accepted (min 2).
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 roll_in  input  1  raw roll push-button, asynchronous to clock, may bounce.
REQ-005 rolling  output  1  high while the FSM is in ROLLING.
REQ-006 roll_valid  output  1  one-cycle pulse: die1/die2/sum hold a new result.
REQ-007 die1  output  3  first die result, 1..6; 0 means no roll since reset.
REQ-008 die2  output  3  second die result, 1..6; 0 means no roll since reset.
REQ-009 sum  output  4  die1+die2, 2..12; 0 means no roll since reset.

Function
REQ-010 roll_in SHALL pass through a 2-flop synchronizer; its second stage is roll_s.
REQ-011 Debouncer SHALL hold roll_db and a mismatch counter; each edge with roll_s != roll_db increments the counter, any edge with roll_s == roll_db clears it.
REQ-012 On the edge where the DEBOUNCE_CYCLES-th consecutive mismatch is sampled, roll_db SHALL take roll_s and the counter SHALL clear.
REQ-013 Net latency: a clean roll_in transition SHALL change roll_db on the (2+DEBOUNCE_CYCLES)-th rising edge after it.
REQ-014 roll_in pulses/glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL have no effect on roll_db or the FSM.
REQ-015 Free-running counters die1c, die2c (3 bits each) SHALL advance every edge in every FSM state: die1c 1->2->...->6->1; die2c advances one step (same 1..6 wrap) only on edges where die1c == 6.
REQ-016 Counter values outside 1..6 SHALL never occur; k edges after reset release die1c = (k mod 6)+1, die2c = ((k div 6) mod 6)+1.
REQ-017 FSM states: IDLE, ROLLING, REPORT.
REQ-018 IDLE: roll_db == 1 -> ROLLING next edge; else stay.
REQ-019 ROLLING: roll_db == 0 -> REPORT next edge, and on that same edge die1/die2 SHALL latch the current die1c/die2c and sum SHALL latch die1c+die2c (4-bit, no overflow possible); else stay.
REQ-020 REPORT: unconditional -> IDLE next edge; roll_valid SHALL be 1 exactly while in REPORT (one cycle per roll).
REQ-021 die1/die2/sum SHALL hold their latched values until the next REPORT entry or reset; they SHALL never change while roll_valid is 0 except by reset.
REQ-022 roll_db high while in REPORT SHALL be honoured: FSM goes IDLE then ROLLING on successive edges (no press lost).
REQ-023 Outputs SHALL be registered or decoded from FSM state only; no combinational path from roll_in to any output.

Reset
REQ-024 While reset == 0, immediately and regardless of clock: FSM = IDLE, rolling = 0, roll_valid = 0, die1 = die2 = 0, sum = 0.
REQ-025 Reset SHALL clear synchronizer flops, roll_db, and mismatch counter to 0, and set die1c = die2c = 1.
REQ-026 Reset asserted mid-ROLLING or mid-REPORT SHALL abort the roll with no roll_valid pulse; after release, a roll_in still held high SHALL be treated as a new press (ROLLING after 2+DEBOUNCE_CYCLES+1 edges).

Verification (DEBOUNCE_CYCLES = 4)
REQ-027 Assert reset=0 for 2 cycles, roll_in=0 -> rolling=0, roll_valid=0, die1=die2=sum=0 during and after reset; no output change for 50 idle cycles.
REQ-028 roll_in 0->1 clean, held 20 cycles -> rolling rises after the 7th edge following the change; then roll_in 1->0 -> rolling falls and roll_valid high for exactly one cycle after the 7th edge following the fall, die1/die2 in 1..6, sum == die1+die2.
REQ-029 roll_in high for 3 synchronized cycles then low (and a 1-0-1 bounce train of 2-cycle pulses) -> rolling stays 0, roll_valid never asserts.
REQ-030 Release reset, time press so the ROLLING->REPORT edge is edge k=35 after release -> die1=6, die2=6, sum=12; repeat with k=7 -> die1=2, die2=2, sum=4.
REQ-031 Assert reset while rolling=1 with roll_in held high -> outputs 0 immediately, no roll_valid; after release rolling re-asserts after the 7th edge.
REQ-032 Two back-to-back presses with 6-cycle gaps -> exactly two roll_valid pulses, each result latched and stable until the next pulse.
